mem_store: RTL and testbench
============================

MEM_STORE -- requirements
Module: mem_store

Interface
REQ-001 SHALL have parameter AW, default 6: address MSB index; addresses are AW+1 bits wide.
REQ-002 SHALL have parameter EXTRA, default 4: width of the extra-bytes field; data bus is 2**EXTRA*8 bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  store request present.
REQ-006 SHALL have port req_ready  output  1  engine idle; accepts a request this cycle.
REQ-007 SHALL have port req_addr  input  AW+1  first byte address.
REQ-008 SHALL have port req_extra  input  EXTRA  byte count minus one.
REQ-009 SHALL have port req_data  input  2**EXTRA*8  little-endian store payload.
REQ-010 SHALL have port lower_bound  input  AW+1  lowest writable address, inclusive.
REQ-011 SHALL have port upper_bound  input  AW+1  highest writable address, inclusive.
REQ-012 SHALL have port ram_we  output  1  byte write strobe.
REQ-013 SHALL have port ram_addr  output  AW+1  byte write address.
REQ-014 SHALL have port ram_wdata  output  8  byte write data.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port error  output  1  one-cycle fault pulse, coincident with done.

Function
REQ-017 SHALL implement states IDLE, WRITE and FINISH, with IDLE entered on reset.
REQ-018 SHALL drive req_ready high only in IDLE.
REQ-019 SHALL accept a request on a rising edge with req_valid and req_ready both high, and SHALL latch addr, extra and data on that edge.
REQ-020 SHALL fault a request when addr+extra exceeds 2**(AW+1)-1; the bound is computed AW+2 bits wide, with no wrap-around.
REQ-021 SHALL also fault a request when the bounds feature is compiled in and addr < lower_bound or addr+extra > upper_bound.
REQ-022 SHALL, on a faulted request, go directly to FINISH with no ram_we, and pulse done=1 and error=1 in the cycle after acceptance.
REQ-023 SHALL, on a valid request, go to WRITE and emit extra+1 consecutive cycles with ram_we=1, starting the cycle after acceptance.
REQ-024 SHALL, in WRITE beat i, drive ram_addr=addr+i and ram_wdata=data[8i+7:8i].
REQ-025 SHALL enter FINISH after the last beat, pulse done=1 and error=0 for one cycle, then return to IDLE.
REQ-026 SHALL give total latency from acceptance to done of extra+2 cycles for a valid request and 1 cycle for a faulted one.
REQ-027 SHALL ignore req_valid outside IDLE; a held request is taken on the first IDLE cycle after FINISH.
REQ-028 SHALL register all outputs; ram_addr and ram_wdata are don't-care when ram_we=0 but SHALL be held at 0.

Reset
REQ-029 SHALL, on reset low, immediately force IDLE with ram_we=0, ram_addr=0, ram_wdata=0, done=0, error=0 and req_ready=1.
REQ-030 SHALL, on reset asserted mid-WRITE, abandon the remaining beats with no further writes and no done pulse.

Configuration
REQ-031 SHALL honour macro MEM_STORE_BOUNDS_EN: when it is defined, the REQ-021 bounds check is active.
REQ-032 SHALL, when MEM_STORE_BOUNDS_EN is undefined, leave lower_bound and upper_bound present but unused, and fault only on REQ-020 overflow.

Verification
REQ-033 SHALL be verified by: addr=10, extra=3, data=0x44332211, bounds 0..127 -> writes 0x11@10, 0x22@11, 0x33@12, 0x44@13 in cycles 1-4; done=1, error=0 in cycle 5.
REQ-034 SHALL be verified by: addr=126, extra=3 -> error=1, done=1 in cycle 1; zero ram_we cycles.
REQ-035 SHALL be verified by: BOUNDS_EN defined, lower=32, upper=63, addr=62, extra=1 -> write 62 and 63, no error; addr=63, extra=1 -> error=1, no writes.
REQ-036 SHALL be verified by: BOUNDS_EN undefined, lower=32, upper=63, addr=0, extra=0, data=0xAB -> 0xAB@0, done, no error.
REQ-037 SHALL be verified by: reset low during beat 2 of an extra=7 store -> ram_we=0 at once, no done; after release req_ready=1 and a new store completes normally.
REQ-038 SHALL be verified by: req_valid held high across two back-to-back extra=0 stores -> second acceptance on the cycle after the first done, 3 cycles apart.

Source files
------------

// File: rtl/mem_store.sv
// -----------------------------------------------------------------------------
// mem_store
//
// Byte-serial store engine. A request carries a first byte address, a byte
// count minus one (req_extra) and a little-endian payload. An accepted request
// is either faulted (it would run past the top of the address space, or, with
// the bounds feature compiled in, leave the writable window) or written out as
// req_extra+1 consecutive single-byte RAM writes. Either way the engine ends
// with a one-cycle done pulse (error coincident for a fault), then returns to
// idle.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready is high only while the engine is idle;
// req_valid is ignored otherwise, so a held request is taken on the first
// idle cycle after the done pulse.
//
// Optional feature: define MEM_STORE_BOUNDS_EN to also fault requests with
// req_addr < lower_bound or req_addr+req_extra > upper_bound. Without it the
// bound ports remain on the interface but are ignored.
//
// Parameters
//   AW     address MSB index; addresses are AW+1 bits
//   EXTRA  width of req_extra; payload is 2**EXTRA bytes
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   req_valid    store request present
//   req_ready    engine idle, request accepted this cycle (registered)
//   req_addr     first byte address
//   req_extra    byte count minus one
//   req_data     little-endian payload, byte i at [8i+7:8i]
//   lower_bound  lowest writable address, inclusive
//   upper_bound  highest writable address, inclusive
//   ram_we       byte write strobe (registered)
//   ram_addr     byte write address, 0 when ram_we=0 (registered)
//   ram_wdata    byte write data, 0 when ram_we=0 (registered)
//   done         one-cycle completion pulse (registered)
//   error        one-cycle fault pulse, coincident with done (registered)
//   dbg_state    current FSM state (0 IDLE, 1 WRITE, 2 FINISH)
// -----------------------------------------------------------------------------
module mem_store #(
    parameter int AW    = 6,
    parameter int EXTRA = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [AW:0]               req_addr,
    input  logic [EXTRA-1:0]          req_extra,
    input  logic [(2**EXTRA)*8-1:0]   req_data,
    input  logic [AW:0]               lower_bound,
    input  logic [AW:0]               upper_bound,
    output logic                      ram_we,
    output logic [AW:0]               ram_addr,
    output logic [7:0]                ram_wdata,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                dbg_state
);

    localparam int AWW = AW + 1;
    localparam int DW  = (2**EXTRA) * 8;
    // Sum width: wide enough that addr+extra can never wrap.
    localparam int SW  = (AW + 2 > EXTRA + 1) ? AW + 2 : EXTRA + 1;
    localparam logic [SW-1:0] ADDR_MAX = SW'((2**AWW) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [EXTRA-1:0] left_q, left_nx;     // beats still to go after the current one
    logic [DW-1:0]    data_q, data_nx;     // payload, next byte kept in [7:0]

    logic             ready_nx;
    logic             we_nx;
    logic [AW:0]      addr_nx;
    logic [7:0]       wdata_nx;
    logic             done_nx;
    logic             error_nx;

    logic             accept;
    logic [SW-1:0]    last_byte;
    logic             fault;

    assign accept    = req_valid && req_ready;
    assign last_byte = SW'(req_addr) + SW'(req_extra);

`ifdef MEM_STORE_BOUNDS_EN
    assign fault = (last_byte > ADDR_MAX)
                || (req_addr < lower_bound)
                || (last_byte > SW'(upper_bound));
`else
    logic unused_bounds;
    assign unused_bounds = ^{lower_bound, upper_bound};
    assign fault = (last_byte > ADDR_MAX);
`endif

    assign dbg_state = state;

    // Next state and next registered outputs. Outputs default to the idle
    // values so address/data read 0 whenever no write is in flight.
    always_comb begin
        state_nx = state;
        left_nx  = left_q;
        data_nx  = data_q;
        ready_nx = 1'b0;
        we_nx    = 1'b0;
        addr_nx  = '0;
        wdata_nx = '0;
        done_nx  = 1'b0;
        error_nx = 1'b0;

        case (state)
            IDLE: begin
                ready_nx = 1'b1;
                if (accept) begin
                    ready_nx = 1'b0;
                    if (fault) begin
                        state_nx = FINISH;
                        done_nx  = 1'b1;
                        error_nx = 1'b1;
                    end else begin
                        // Beat 0 goes out in the cycle right after acceptance.
                        state_nx = WRITE;
                        we_nx    = 1'b1;
                        addr_nx  = req_addr;
                        wdata_nx = req_data[7:0];
                        data_nx  = req_data >> 8;
                        left_nx  = req_extra;
                    end
                end
            end

            WRITE: begin
                if (left_q == '0) begin
                    state_nx = FINISH;
                    done_nx  = 1'b1;
                end else begin
                    we_nx    = 1'b1;
                    addr_nx  = ram_addr + AWW'(1);
                    wdata_nx = data_q[7:0];
                    data_nx  = data_q >> 8;
                    left_nx  = left_q - EXTRA'(1);
                end
            end

            FINISH: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end

            default: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            left_q    <= '0;
            data_q    <= '0;
            req_ready <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nx;
            left_q    <= left_nx;
            data_q    <= data_nx;
            req_ready <= ready_nx;
            ram_we    <= we_nx;
            ram_addr  <= addr_nx;
            ram_wdata <= wdata_nx;
            done      <= done_nx;
            error     <= error_nx;
        end
    end

endmodule

// File: tb/tb_mem_store.sv
// -----------------------------------------------------------------------------
// tb_mem_store
//
// Self-checking bench for mem_store. A transaction-level model predicts, for
// every accepted request, which cycles carry writes, what bytes land where,
// and when done/error pulse; a compare process checks every DUT output on
// every cycle out of reset. Directed transactions additionally pin results to
// hand-computed literals. Build with MEM_STORE_BOUNDS_EN defined to exercise
// the bounds window.
// -----------------------------------------------------------------------------
module tb_mem_store;

    localparam int AW    = 6;
    localparam int EXTRA = 4;
    localparam int DW    = (2**EXTRA) * 8;
    localparam int W     = AW + 1 + 8;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic [AW:0]      req_addr = '0;
    logic [EXTRA-1:0] req_extra = '0;
    logic [DW-1:0]    req_data = '0;
    logic [AW:0]      lower_bound = '0;
    logic [AW:0]      upper_bound = 7'd127;
    logic             req_ready;
    logic             ram_we;
    logic [AW:0]      ram_addr;
    logic [7:0]       ram_wdata;
    logic             done;
    logic             error;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    mem_store #(.AW(AW), .EXTRA(EXTRA)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_extra   (req_extra),
        .req_data    (req_data),
        .lower_bound (lower_bound),
        .upper_bound (upper_bound),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .done        (done),
        .error       (error),
        .dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    // cyc numbers the interval after each rising edge. A request taken on
    // edge a writes in intervals a..a+extra and is done in a+extra+1; a
    // faulted one is done in interval a. Idle again the interval after done.
    int              cyc = 0;
    int              last_done = -1;
    bit              exp_we[int];
    bit              exp_done[int];      // value = expected error bit
    logic [W-1:0]    exp_q[$];           // {addr, byte} in write order

    function automatic void model_accept(input int a, input int addr, input int extra,
                                         input logic [DW-1:0] data);
        int last;
        bit flt;
        logic [AW:0] ta;
        last = addr + extra;
        flt  = (last > 127);
`ifdef MEM_STORE_BOUNDS_EN
        flt = flt || (addr < int'(lower_bound)) || (last > int'(upper_bound));
`endif
        if (flt) begin
            exp_done[a] = 1'b1;
            last_done   = a;
        end else begin
            for (int i = 0; i <= extra; i++) begin
                exp_we[a+i] = 1'b1;
                ta = (AW+1)'(addr + i);
                exp_q.push_back({ta, data[8*i +: 8]});
            end
            exp_done[a+extra+1] = 1'b0;
            last_done = a + extra + 1;
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_we.delete();
            exp_done.delete();
            exp_q.delete();
            last_done = -1;
        end else begin
            if (req_valid && (cyc > last_done))
                model_accept(cyc + 1, int'(req_addr), int'(req_extra), req_data);
            cyc = cyc + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    int           k;
    bit           we_e, done_e, err_e, rdy_e;
    logic [W-1:0] w;

    always @(negedge clk) begin
        if (reset) begin
            k      = cyc;
            we_e   = exp_we.exists(k);
            done_e = exp_done.exists(k);
            err_e  = done_e && exp_done[k];
            rdy_e  = (k > last_done);
            check("ram_we", ram_we, we_e);
            check("done", done, done_e);
            check("error", error, err_e);
            check("req_ready", req_ready, rdy_e);
            if (we_e) begin
                if (exp_q.size() == 0) begin
                    check("write_queue_empty", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("ram_addr", ram_addr, w[W-1:8]);
                    check("ram_wdata", ram_wdata, w[7:0]);
                end
            end else begin
                check("ram_addr_idle", ram_addr, 0);
                check("ram_wdata_idle", ram_wdata, 0);
            end
        end
    end

    // ---------------- write monitor for literal checks ----------------
    logic [AW:0] obs_addr[$];
    logic [7:0]  obs_data[$];
    int          obs_cyc[$];

    always @(negedge clk) begin
        if (reset && ram_we) begin
            obs_addr.push_back(ram_addr);
            obs_data.push_back(ram_wdata);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
    endtask

    // ---------------- driver ----------------
    // Issues one request from idle and returns at the done cycle with the
    // latency (cycles from acceptance to done) and the error bit seen.
    task automatic run_store(input int addr, input int extra, input logic [DW-1:0] data,
                             output int lat, output bit err);
        clear_obs();
        @(negedge clk);
        req_addr  = (AW+1)'(addr);
        req_extra = EXTRA'(extra);
        req_data  = data;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 0, 1);
        err = error;
    endtask

    task automatic check_writes(input string name, input int n, input int base,
                                input logic [DW-1:0] data);
        check({name, "_count"}, obs_addr.size(), n);
        if (obs_addr.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check({name, "_addr"}, obs_addr[i], base + i);
                check({name, "_data"}, obs_data[i], data[8*i +: 8]);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    localparam logic [DW-1:0] PAT_A = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [DW-1:0] PAT_B = 128'hf1e2d3c4b5a69788796a5b4c3d2e1f00;

    int lat;
    bit err;
    int seen_done;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b1;
        @(negedge clk);

        // four-byte store, literal bytes 0x11..0x44 at 10..13
        run_store(10, 3, 128'h44332211, lat, err);
        check("t1_latency", lat, 5);
        check("t1_error", err, 0);
        check("t1_count", obs_addr.size(), 4);
        if (obs_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_addr", obs_addr[i], 10 + i);
                check("t1_data", obs_data[i], 8'h11 * (i + 1));
            end
            check("t1_consecutive", obs_cyc[3] - obs_cyc[0], 3);
        end

        // runs past address 127
        run_store(126, 3, 128'hdeadbeef, lat, err);
        check("t2_latency", lat, 1);
        check("t2_error", err, 1);
        check("t2_count", obs_addr.size(), 0);

        // window 32..63
        lower_bound = 7'd32;
        upper_bound = 7'd63;
        run_store(62, 1, 128'hbeef, lat, err);
        check("t3a_latency", lat, 3);
        check("t3a_error", err, 0);
        check_writes("t3a", 2, 62, 128'hbeef);

        run_store(63, 1, 128'h5a5a, lat, err);
`ifdef MEM_STORE_BOUNDS_EN
        check("t3b_latency", lat, 1);
        check("t3b_error", err, 1);
        check("t3b_count", obs_addr.size(), 0);
`else
        check("t3b_latency", lat, 3);
        check("t3b_error", err, 0);
        check_writes("t3b", 2, 63, 128'h5a5a);
`endif

        run_store(0, 0, 128'hab, lat, err);
`ifdef MEM_STORE_BOUNDS_EN
        check("t3c_latency", lat, 1);
        check("t3c_error", err, 1);
        check("t3c_count", obs_addr.size(), 0);
`else
        check("t3c_latency", lat, 2);
        check("t3c_error", err, 0);
        check_writes("t3c", 1, 0, 128'hab);
`endif
        lower_bound = 7'd0;
        upper_bound = 7'd127;

        // top-of-space edges
        run_store(127, 0, 128'hc3, lat, err);
        check("t4a_latency", lat, 2);
        check("t4a_error", err, 0);
        check_writes("t4a", 1, 127, 128'hc3);

        run_store(112, 15, PAT_A, lat, err);
        check("t4b_latency", lat, 17);
        check("t4b_error", err, 0);
        check_writes("t4b", 16, 112, PAT_A);
        if (obs_data.size() == 16) check("t4b_last_byte", obs_data[15], 8'h0f);

        run_store(113, 15, PAT_A, lat, err);
        check("t4c_latency", lat, 1);
        check("t4c_error", err, 1);

        run_store(0, 15, PAT_B, lat, err);
        check("t4d_latency", lat, 17);
        check("t4d_error", err, 0);

        // reset in beat 2 of an eight-byte store
        clear_obs();
        @(negedge clk);
        req_addr  = 7'd20;
        req_extra = 4'd7;
        req_data  = PAT_B;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_beat2_we", ram_we, 1);
        check("t5_beat2_addr", ram_addr, 22);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_we", ram_we, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_ready", req_ready, 1);
        check("t5_rst_addr", ram_addr, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || ram_we) seen_done++;
        end
        check("t5_no_activity", seen_done, 0);
        check("t5_writes_before_reset", obs_addr.size(), 3);

        run_store(40, 1, 128'h9988, lat, err);
        check("t5_after_latency", lat, 3);
        check("t5_after_error", err, 0);
        check_writes("t5_after", 2, 40, 128'h9988);

        // held req_valid over two single-byte stores
        clear_obs();
        @(negedge clk);
        req_addr  = 7'd5;
        req_extra = 4'd0;
        req_data  = 128'h77;
        req_valid = 1'b1;
        repeat (4) @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_count", obs_addr.size(), 2);
        if (obs_cyc.size() == 2) begin
            check("t6_spacing", obs_cyc[1] - obs_cyc[0], 3);
            check("t6_data", obs_data[1], 8'h77);
        end

        repeat (2) @(negedge clk);
        check("model_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
